// File: rtl/tl_a_pkg.sv
// Shared TileLink A-channel definitions: opcode encodings, default field
// widths and the packed beat record used by A-channel stages.
package tl_a_pkg;

   localparam int unsigned TL_ADDR_W   = 32;
   localparam int unsigned TL_SOURCE_W = 7;
   localparam int unsigned TL_SIZE_W   = 3;
   localparam int unsigned TL_MASK_W   = 4;
   localparam int unsigned TL_DATA_W   = 8 * TL_MASK_W;

   localparam logic [2:0] PUT_FULL      = 3'd0;
   localparam logic [2:0] PUT_PARTIAL   = 3'd1;
   localparam logic [2:0] ARITH         = 3'd2;
   localparam logic [2:0] LOGIC         = 3'd3;
   localparam logic [2:0] GET           = 3'd4;
   localparam logic [2:0] HINT          = 3'd5;
   localparam logic [2:0] ACQUIRE_BLOCK = 3'd6;
   localparam logic [2:0] ACQUIRE_PERM  = 3'd7;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [2:0]             param;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic [TL_ADDR_W-1:0]   address;
      logic [TL_MASK_W-1:0]   mask;
      logic [TL_DATA_W-1:0]   data;
      logic                   corrupt;
   } tl_a_beat_t;

   // Only full-mask reads and writes may legally be held for replay.
   function automatic logic repeat_allowed(input logic [2:0] opcode);
      return (opcode == GET) || (opcode == PUT_FULL);
   endfunction

endpackage

// File: rtl/tl_a_repeater_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear, hold at all-ones, or step by one.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tl_a_repeater.sv
// One-entry TileLink A-channel repeater. Beats pass straight through until
// the downstream stage fires with the repeat request; that beat is captured
// and replayed (upstream stalled) until a fire without repeat releases it.
// The repeat request port is named repeat_i because `repeat` is reserved.
module tl_a_repeater
   import tl_a_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned SOURCE_W = 7,
   parameter int unsigned SIZE_W   = 3,
   parameter int unsigned MASK_W   = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   // upstream A channel
   input  logic                  enq_valid,
   output logic                  enq_ready,
   input  logic [2:0]            enq_opcode,
   input  logic [2:0]            enq_param,
   input  logic [SIZE_W-1:0]     enq_size,
   input  logic [SOURCE_W-1:0]   enq_source,
   input  logic [ADDR_W-1:0]     enq_address,
   input  logic [MASK_W-1:0]     enq_mask,
   input  logic [8*MASK_W-1:0]   enq_data,
   input  logic                  enq_corrupt,
   // downstream A channel
   output logic                  deq_valid,
   input  logic                  deq_ready,
   output logic [2:0]            deq_opcode,
   output logic [2:0]            deq_param,
   output logic [SIZE_W-1:0]     deq_size,
   output logic [SOURCE_W-1:0]   deq_source,
   output logic [ADDR_W-1:0]     deq_address,
   output logic [MASK_W-1:0]     deq_mask,
   output logic [8*MASK_W-1:0]   deq_data,
   output logic                  deq_corrupt,
   // repeat control and status
   input  logic                  repeat_i,
   output logic                  full,
   output logic [MASK_W-1:0]     saved_mask,
   output logic [CNT_W-1:0]      repeat_cnt,
   output logic                  protocol_err
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_e;

   state_e     state_q;
   tl_a_beat_t beat_q;
   logic       err_q;

   tl_a_beat_t enq_beat;
   tl_a_beat_t deq_beat;
   logic       held;
   logic       deq_fire;
   logic       cnt_clr;
   logic       cnt_inc;

   assign held = (state_q == ST_HELD);

   // Pack the upstream payload into the shared beat record.
   always_comb begin
      enq_beat         = '0;
      enq_beat.opcode  = enq_opcode;
      enq_beat.param   = enq_param;
      enq_beat.size    = enq_size;
      enq_beat.source  = enq_source;
      enq_beat.address = enq_address;
      enq_beat.mask    = enq_mask;
      enq_beat.data    = enq_data;
      enq_beat.corrupt = enq_corrupt;
   end

   // Zero-latency handshake: replaying beats own the output and stall upstream.
   assign deq_valid = enq_valid | held;
   assign enq_ready = deq_ready & ~held;
   assign deq_fire  = deq_valid & deq_ready;
   assign deq_beat  = held ? beat_q : enq_beat;

   assign deq_opcode  = deq_beat.opcode;
   assign deq_param   = deq_beat.param;
   assign deq_size    = deq_beat.size;
   assign deq_source  = deq_beat.source;
   assign deq_address = deq_beat.address;
   assign deq_mask    = deq_beat.mask;
   assign deq_data    = deq_beat.data;
   assign deq_corrupt = deq_beat.corrupt;

   // Capture/replay state, held payload and sticky protocol error.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (deq_fire && repeat_i && !repeat_allowed(deq_beat.opcode)) begin
            err_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (deq_fire && repeat_i) begin
                  state_q <= ST_HELD;
                  beat_q  <= enq_beat;
               end
            end
            ST_HELD: begin
               if (deq_fire && !repeat_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Counter restarts on capture and release; only replays while held step it.
   assign cnt_inc = deq_fire & held & repeat_i;
   assign cnt_clr = deq_fire & ~(held & repeat_i);

   sat_counter #(
      .W (CNT_W)
   ) u_repeat_cnt (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .cnt_o  (repeat_cnt)
   );

   assign full         = held;
   assign saved_mask   = held ? beat_q.mask : '0;
   assign protocol_err = err_q;

endmodule
